// File: rtl/gps_gate_sequencer.sv
// Sequencer for the GPS-gated frequency counter. It turns GPS pulse edges into clear, latch and run
// controls for the counter datapath, and reports result, overrun and missing-pulse status.
//
// state      | meaning
// -----------+-----------------------------------------------------------------
// ST_IDLE    | disabled; edges ignored, gate closed, timeout held
// ST_ARM     | waiting for the first edge to open a window; timeout running
// ST_MEASURE | window open, gate running; closes after avg_active+1 pulse gaps
module gps_gate_sequencer #(
  parameter int AVG_WIDTH      = 5,
  parameter int TIMEOUT_WIDTH  = 28,
  parameter int TIMEOUT_CYCLES = 110000000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                 system_clk_i,
  input  logic                 rst_n_i,
  input  logic                 gps_pulse_i,
  input  logic                 enable_i,
  input  logic [AVG_WIDTH-1:0] cfg_average_i,
  input  logic                 cfg_load_i,
  input  logic                 result_ack_i,
  output logic                 gate_run_o,
  output logic                 gate_clear_o,
  output logic                 gate_latch_o,
  output logic                 result_valid_o,
  output logic                 pulse_missing_o,
  output logic                 overrun_o,
  output logic                 irq_o,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARM     = 2'b01,
    ST_MEASURE = 2'b10
  } state_t;

  // Down-counter reload value: cycles left before the current interval counts as a missing pulse.
  localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                   state_q;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     sync_prev_q;
  logic [AVG_WIDTH-1:0]     avg_shadow_q;
  logic [AVG_WIDTH-1:0]     avg_active_q;
  logic [AVG_WIDTH-1:0]     pulse_cnt_q;
  logic [TIMEOUT_WIDTH-1:0] timeout_left_q;
  logic                     gate_run_q;
  logic                     gate_clear_q;
  logic                     gate_latch_q;
  logic                     result_valid_q;
  logic                     pulse_missing_q;
  logic                     overrun_q;
  logic                     irq_q;

  logic                     sync_s;
  logic                     rise;
  logic                     timeout_hit;
  logic                     win_close;
  logic                     fault;
  logic                     result_valid_d;
  logic                     pulse_missing_d;
  logic                     overrun_d;
  logic [AVG_WIDTH-1:0]     avg_next_win;

  assign sync_s      = sync_q[SYNC_STAGES-1];
  assign rise        = sync_s & ~sync_prev_q;
  assign timeout_hit = (timeout_left_q == '0);

  always_comb begin
    win_close = 1'b0;
    fault     = 1'b0;
    case (state_q)
      ST_ARM:     fault = enable_i & ~rise & timeout_hit;
      ST_MEASURE: begin
        win_close = enable_i & rise & (pulse_cnt_q == avg_active_q);
        fault     = enable_i & ~rise & timeout_hit;
      end
      default: ;
    endcase
    // A set in the same cycle as an ack wins; an acked old result never counts as overrun.
    result_valid_d  = win_close | (result_valid_q & ~result_ack_i);
    overrun_d       = (win_close & result_valid_q & ~result_ack_i) | (overrun_q & ~result_ack_i);
    pulse_missing_d = fault | (pulse_missing_q & ~result_ack_i);
    avg_next_win    = cfg_load_i ? cfg_average_i : avg_shadow_q;
  end

  always_ff @(posedge system_clk_i) begin
    if (!rst_n_i) begin
      state_q         <= ST_IDLE;
      sync_q          <= '0;
      sync_prev_q     <= 1'b0;
      avg_shadow_q    <= '0;
      avg_active_q    <= '0;
      pulse_cnt_q     <= '0;
      timeout_left_q  <= '0;
      gate_run_q      <= 1'b0;
      gate_clear_q    <= 1'b0;
      gate_latch_q    <= 1'b0;
      result_valid_q  <= 1'b0;
      pulse_missing_q <= 1'b0;
      overrun_q       <= 1'b0;
      irq_q           <= 1'b0;
    end else begin
      sync_q          <= {sync_q[SYNC_STAGES-2:0], gps_pulse_i};
      sync_prev_q     <= sync_s;
      result_valid_q  <= result_valid_d;
      pulse_missing_q <= pulse_missing_d;
      overrun_q       <= overrun_d;
      irq_q           <= result_valid_d | pulse_missing_d;
      gate_clear_q    <= 1'b0;
      gate_latch_q    <= 1'b0;
      if (cfg_load_i) begin
        avg_shadow_q <= cfg_average_i;
      end

      if (!enable_i) begin
        state_q        <= ST_IDLE;
        gate_run_q     <= 1'b0;
        pulse_cnt_q    <= '0;
        timeout_left_q <= TO_LAST;
        if (cfg_load_i && state_q != ST_MEASURE) begin
          avg_active_q <= cfg_average_i;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            gate_run_q     <= 1'b0;
            pulse_cnt_q    <= '0;
            timeout_left_q <= TO_LAST;
            if (cfg_load_i) begin
              avg_active_q <= cfg_average_i;
            end
            state_q <= ST_ARM;
          end

          ST_ARM: begin
            gate_run_q <= 1'b0;
            if (rise) begin
              gate_clear_q   <= 1'b1;
              pulse_cnt_q    <= '0;
              avg_active_q   <= avg_next_win;
              timeout_left_q <= TO_LAST;
              state_q        <= ST_MEASURE;
            end else begin
              if (cfg_load_i) begin
                avg_active_q <= cfg_average_i;
              end
              if (timeout_hit) begin
                timeout_left_q <= TO_LAST;
              end else begin
                timeout_left_q <= timeout_left_q - 1'b1;
              end
            end
          end

          ST_MEASURE: begin
            gate_run_q <= 1'b1;
            if (rise) begin
              timeout_left_q <= TO_LAST;
              if (pulse_cnt_q == avg_active_q) begin
                // Latch and clear together: datapath copies the old count, then restarts at zero.
                gate_latch_q <= 1'b1;
                gate_clear_q <= 1'b1;
                pulse_cnt_q  <= '0;
                avg_active_q <= avg_next_win;
              end else begin
                pulse_cnt_q <= pulse_cnt_q + 1'b1;
              end
            end else if (timeout_hit) begin
              gate_clear_q   <= 1'b1;
              gate_run_q     <= 1'b0;
              pulse_cnt_q    <= '0;
              avg_active_q   <= avg_next_win;
              timeout_left_q <= TO_LAST;
              state_q        <= ST_ARM;
            end else begin
              timeout_left_q <= timeout_left_q - 1'b1;
            end
          end

          default: begin
            gate_run_q     <= 1'b0;
            pulse_cnt_q    <= '0;
            timeout_left_q <= TO_LAST;
            state_q        <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign gate_run_o      = gate_run_q;
  assign gate_clear_o    = gate_clear_q;
  assign gate_latch_o    = gate_latch_q;
  assign result_valid_o  = result_valid_q;
  assign pulse_missing_o = pulse_missing_q;
  assign overrun_o       = overrun_q;
  assign irq_o           = irq_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_gps_gate_sequencer.sv
// Bench for gps_gate_sequencer: directed scenarios with cycle-exact checks, then random pulse
// trains compared against a per-pulse window model.
module tb_gps_gate_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       gps;
  logic       enable;
  logic [4:0] cfg;
  logic       load;
  logic       ack;
  logic       gate_run_o, gate_clear_o, gate_latch_o;
  logic       result_valid_o, pulse_missing_o, overrun_o, irq_o;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;
  int lat_cnt = 0, clr_cnt = 0, lat_no_clr = 0, dbl = 0;
  logic prev_lat = 1'b0, prev_clr = 1'b0;

  gps_gate_sequencer #(
    .AVG_WIDTH(5), .TIMEOUT_WIDTH(28), .TIMEOUT_CYCLES(50), .SYNC_STAGES(2)
  ) dut (
    .system_clk_i(clk), .rst_n_i(rst_n), .gps_pulse_i(gps), .enable_i(enable),
    .cfg_average_i(cfg), .cfg_load_i(load), .result_ack_i(ack),
    .gate_run_o(gate_run_o), .gate_clear_o(gate_clear_o), .gate_latch_o(gate_latch_o),
    .result_valid_o(result_valid_o), .pulse_missing_o(pulse_missing_o), .overrun_o(overrun_o),
    .irq_o(irq_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Strobe monitor: counts every strobe cycle, plus any strobe lasting two cycles or latch without clear.
  always @(posedge clk) begin
    if (gate_latch_o === 1'b1) lat_cnt++;
    if (gate_clear_o === 1'b1) clr_cnt++;
    if (gate_latch_o === 1'b1 && gate_clear_o !== 1'b1) lat_no_clr++;
    if ((gate_latch_o === 1'b1 && prev_lat) || (gate_clear_o === 1'b1 && prev_clr)) dbl++;
    prev_lat = (gate_latch_o === 1'b1);
    prev_clr = (gate_clear_o === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Pin rises now, is processed at the third following edge (N3), falls at N4.
  task automatic pulse(input int gap, input bit do_load, input int lv, input bit do_ack,
                       output int nlat, output int nclr);
    int l0, c0;
    l0 = lat_cnt;
    c0 = clr_cnt;
    gps = 1'b1;
    tick(2);
    if (do_load) begin
      cfg  = 5'(lv);
      load = 1'b1;
    end
    if (do_ack) ack = 1'b1;
    tick(1);
    load = 1'b0;
    ack  = 1'b0;
    tick(1);
    gps = 1'b0;
    tick(gap - 4);
    nlat = lat_cnt - l0;
    nclr = clr_cnt - c0;
  endtask

  initial begin
    int nl, nc, l0;
    int m_meas, m_cnt, m_active, m_shadow, m_rv, m_ov, m_pm;
    int el, ec, lv, gap, r;
    bit cl, ca, boundary, was_meas;

    rst_n = 1'b0; gps = 1'b0; enable = 1'b0; cfg = '0; load = 1'b0; ack = 1'b0;
    tick(3);
    chk2("rst_state", state_o, 2'd0);
    chk1("rst_run", gate_run_o, 1'b0);
    chk1("rst_clear", gate_clear_o, 1'b0);
    chk1("rst_latch", gate_latch_o, 1'b0);
    chk1("rst_rv", result_valid_o, 1'b0);
    chk1("rst_pm", pulse_missing_o, 1'b0);
    chk1("rst_ov", overrun_o, 1'b0);
    chk1("rst_irq", irq_o, 1'b0);

    // Scenario 1: cfg 2, pulses every 20 cycles; windows close on pulses 4, 7, 10.
    rst_n = 1'b1; enable = 1'b1; cfg = 5'd2; load = 1'b1;
    tick(1);
    load = 1'b0;
    chk2("s1_arm", state_o, 2'd1);
    gps = 1'b1;
    tick(3);
    chk1("s1_p1_clear", gate_clear_o, 1'b1);
    chk1("s1_p1_latch", gate_latch_o, 1'b0);
    chk1("s1_p1_run_lag", gate_run_o, 1'b0);
    chk2("s1_p1_state", state_o, 2'd2);
    tick(1);
    chk1("s1_p1_clear_1cyc", gate_clear_o, 1'b0);
    chk1("s1_p1_run", gate_run_o, 1'b1);
    gps = 1'b0;
    tick(16);
    for (int p = 2; p <= 3; p++) begin
      pulse(20, 1'b0, 0, 1'b0, nl, nc);
      chki("s1_mid_latch", nl, 0);
      chki("s1_mid_clear", nc, 0);
    end
    gps = 1'b1;
    tick(2);
    chk1("s1_p4_rv_early", result_valid_o, 1'b0);
    tick(1);
    chk1("s1_p4_latch", gate_latch_o, 1'b1);
    chk1("s1_p4_clear", gate_clear_o, 1'b1);
    chk1("s1_p4_rv", result_valid_o, 1'b1);
    chk1("s1_p4_irq", irq_o, 1'b1);
    chk1("s1_p4_run", gate_run_o, 1'b1);
    tick(1);
    chk1("s1_p4_latch_1cyc", gate_latch_o, 1'b0);
    gps = 1'b0;
    tick(16);

    // Scenario 2: second latch without ack gives overrun; ack clears all flags next cycle.
    for (int p = 5; p <= 6; p++) begin
      pulse(20, 1'b0, 0, 1'b0, nl, nc);
      chki("s2_mid_latch", nl, 0);
    end
    pulse(20, 1'b0, 0, 1'b0, nl, nc);
    chki("s2_p7_latch", nl, 1);
    chki("s2_p7_clear", nc, 1);
    chk1("s2_p7_ov", overrun_o, 1'b1);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk1("s2_ack_rv", result_valid_o, 1'b0);
    chk1("s2_ack_ov", overrun_o, 1'b0);
    chk1("s2_ack_pm", pulse_missing_o, 1'b0);
    chk1("s2_ack_irq", irq_o, 1'b0);

    // Scenario 5: pulse 10 latches cleanly, then ack coincident with the latch of pulse 13.
    for (int p = 8; p <= 12; p++) begin
      pulse(20, 1'b0, 0, 1'b0, nl, nc);
      chki("s5_latch_count", nl, (p == 10) ? 1 : 0);
    end
    chk1("s5_p10_ov", overrun_o, 1'b0);
    pulse(4, 1'b0, 0, 1'b1, nl, nc);
    chki("s5_p13_latch", nl, 1);
    chk1("s5_ack_rv", result_valid_o, 1'b1);
    chk1("s5_ack_ov", overrun_o, 1'b0);

    // Scenario 3: pulses stop; timeout fires 50 cycles after the last detected edge.
    l0 = lat_cnt;
    tick(48);
    chk1("s3_pm_early", pulse_missing_o, 1'b0);
    chk2("s3_state_early", state_o, 2'd2);
    tick(1);
    chk1("s3_pm", pulse_missing_o, 1'b1);
    chk1("s3_clear", gate_clear_o, 1'b1);
    chk1("s3_latch", gate_latch_o, 1'b0);
    chk1("s3_run", gate_run_o, 1'b0);
    chk2("s3_state", state_o, 2'd1);
    chk1("s3_irq", irq_o, 1'b1);
    tick(1);
    chk1("s3_clear_1cyc", gate_clear_o, 1'b0);
    chki("s3_no_latch", lat_cnt - l0, 0);

    // Scenario 4: cfg 3 window, cfg 0 loaded mid-window; window still takes 4 pulses, then every pulse.
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk1("s4_ack_pm", pulse_missing_o, 1'b0);
    cfg = 5'd3; load = 1'b1;
    tick(1);
    load = 1'b0;
    pulse(20, 1'b0, 0, 1'b0, nl, nc);
    chki("s4_open_clear", nc, 1);
    chki("s4_open_latch", nl, 0);
    pulse(20, 1'b0, 0, 1'b0, nl, nc);
    chki("s4_b_latch", nl, 0);
    cfg = 5'd0; load = 1'b1;
    tick(1);
    load = 1'b0;
    for (int p = 0; p < 2; p++) begin
      pulse(20, 1'b0, 0, 1'b0, nl, nc);
      chki("s4_cd_latch", nl, 0);
    end
    for (int p = 0; p < 3; p++) begin
      pulse(20, 1'b0, 0, 1'b0, nl, nc);
      chki("s4_close_latch", nl, 1);
      chki("s4_close_clear", nc, 1);
    end

    // Scenario 6: disable mid-window, pulses ignored, no timeout; re-enable resumes through ARM.
    enable = 1'b0;
    tick(1);
    chk2("s6_idle", state_o, 2'd0);
    chk1("s6_run", gate_run_o, 1'b0);
    pulse(20, 1'b0, 0, 1'b0, nl, nc);
    chki("s6_dis_latch", nl, 0);
    chki("s6_dis_clear", nc, 0);
    tick(60);
    chk1("s6_no_pm", pulse_missing_o, 1'b0);
    chk2("s6_still_idle", state_o, 2'd0);
    enable = 1'b1;
    tick(1);
    chk2("s6_arm", state_o, 2'd1);
    pulse(20, 1'b0, 0, 1'b0, nl, nc);
    chki("s6_reopen_clear", nc, 1);
    chki("s6_reopen_latch", nl, 0);
    chk2("s6_measure", state_o, 2'd2);
    pulse(20, 1'b0, 0, 1'b0, nl, nc);
    chki("s6_cfg0_latch", nl, 1);

    // Random pulse trains against a per-pulse window model.
    enable = 1'b0;
    tick(1);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    enable = 1'b1;
    tick(1);
    m_meas = 0; m_cnt = 0; m_active = 0; m_shadow = 0; m_rv = 0; m_ov = 0; m_pm = 0;
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 3);
      if (r == 0) begin
        lv = $urandom_range(0, 3);
        cfg = 5'(lv); load = 1'b1;
        tick(1);
        load = 1'b0;
        m_shadow = lv;
        if (m_meas == 0) m_active = lv;
      end else if (r == 1) begin
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        m_rv = 0; m_ov = 0; m_pm = 0;
      end
      cl  = ($urandom_range(0, 4) == 0);
      ca  = ($urandom_range(0, 4) == 0);
      lv  = $urandom_range(0, 3);
      gap = $urandom_range(8, 30);

      was_meas = (m_meas != 0);
      boundary = was_meas && (m_cnt == m_active);
      if (!was_meas) begin
        el = 0; ec = 1; m_meas = 1; m_cnt = 0; m_active = m_shadow;
      end else if (boundary) begin
        el = 1; ec = 1; m_cnt = 0; m_active = m_shadow;
      end else begin
        el = 0; ec = 0; m_cnt++;
      end
      if (cl) begin
        m_shadow = lv;
        if (!was_meas || boundary) m_active = lv;
      end
      if (boundary) begin
        m_ov = (!ca && (m_ov != 0 || m_rv != 0)) ? 1 : 0;
        m_rv = 1;
      end else if (ca) begin
        m_rv = 0; m_ov = 0;
      end
      if (ca) m_pm = 0;

      pulse(gap, cl, lv, ca, nl, nc);
      chki("rnd_latch", nl, el);
      chki("rnd_clear", nc, ec);
      chki("rnd_rv", int'(result_valid_o), m_rv);
      chki("rnd_ov", int'(overrun_o), m_ov);
      chki("rnd_pm", int'(pulse_missing_o), m_pm);
      chki("rnd_irq", int'(irq_o), (m_rv != 0 || m_pm != 0) ? 1 : 0);
      chk2("rnd_state", state_o, 2'd2);
    end

    // Reset while a pulse is being processed: window abandoned, no latch.
    l0 = lat_cnt;
    gps = 1'b1;
    tick(2);
    rst_n = 1'b0;
    tick(1);
    chk2("rstmid_state", state_o, 2'd0);
    chk1("rstmid_run", gate_run_o, 1'b0);
    chk1("rstmid_rv", result_valid_o, 1'b0);
    tick(2);
    gps = 1'b0;
    rst_n = 1'b1;
    tick(2);
    chki("rstmid_no_latch", lat_cnt - l0, 0);

    chki("strobe_single_cycle", dbl, 0);
    chki("latch_implies_clear", lat_no_clr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
